// File: rtl/missile_arbiter.sv
// missile_arbiter: shares a small pool of missile slots between the player
// and up to eight enemies. One grant per cycle at most; the player has strict
// priority, enemies are served round-robin, and each side has its own
// frame-based cooldown. All outputs are registered.
module missile_arbiter #(
    parameter int NUM_SLOTS  = 4,
    parameter int PLAYER_MAX = 2,
    parameter int COOLDOWN   = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_tick,
    input  logic                         play,
    input  logic [7:0]                   keycode,
    input  logic [7:0]                   enemy_req,
    input  logic [NUM_SLOTS-1:0]         slot_free,
    output logic [NUM_SLOTS-1:0]         slot_busy,
    output logic [NUM_SLOTS-1:0]         slot_owner,
    output logic                         grant_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] grant_slot,
    output logic                         grant_player,
    output logic [2:0]                   grant_enemy,
    output logic                         player_ready
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam logic [7:0] FIRE_KEY = 8'h2C;
    localparam logic [4:0] COOL_LOAD = 5'(COOLDOWN);

    // Number of set bits in a slot vector.
    function automatic logic [CW-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt = cnt + {{(CW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Index of the lowest clear bit (caller checks that one exists).
    function automatic logic [SW-1:0] first_zero(input logic [NUM_SLOTS-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = SW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // First requesting enemy found when scanning upward (mod 8) from start.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] cand;
        idx = start;
        for (int k = 7; k >= 0; k--) begin
            cand = start + 3'(k);
            if (req[cand]) begin
                idx = cand;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NUM_SLOTS-1:0] busy_q,  busy_d;
    logic [NUM_SLOTS-1:0] owner_q, owner_d;
    logic [4:0]           pcool_q, pcool_d;
    logic [4:0]           ecool_q, ecool_d;
    logic [2:0]           rr_q,    rr_d;
    logic                 gvalid_q, gvalid_d;
    logic [SW-1:0]        gslot_q,  gslot_d;
    logic                 gplayer_q, gplayer_d;
    logic [2:0]           genemy_q,  genemy_d;
    logic                 ready_q,   ready_d;

    logic                 slot_avail_s;
    logic [SW-1:0]        free_idx_s;
    logic                 player_req_s;
    logic                 enemy_req_s;
    logic [2:0]           enemy_pick_s;

    // Request qualification from registered state; allocation never sees
    // slots released in the current cycle.
    always_comb begin
        slot_avail_s = ~(&busy_q);
        free_idx_s   = first_zero(busy_q);
        player_req_s = (keycode == FIRE_KEY) && (pcool_q == 5'd0) &&
                       (popcount(busy_q & owner_q) < CW'(PLAYER_MAX));
        enemy_req_s  = (enemy_req != 8'h00) && (ecool_q == 5'd0);
        enemy_pick_s = rr_pick(enemy_req, rr_q);
    end

    // Next-state: releases, cooldown aging, and at most one allocation.
    always_comb begin
        busy_d    = busy_q;
        owner_d   = owner_q;
        pcool_d   = pcool_q;
        ecool_d   = ecool_q;
        rr_d      = rr_q;
        gvalid_d  = 1'b0;
        gslot_d   = gslot_q;
        gplayer_d = gplayer_q;
        genemy_d  = genemy_q;
        ready_d   = 1'b0;
        if (!play) begin
            busy_d  = '0;
            owner_d = '0;
            pcool_d = 5'd0;
            ecool_d = 5'd0;
            rr_d    = 3'd0;
        end else begin
            // Releases only affect busy slots; owner bits are never set on idle slots.
            busy_d  = busy_q  & ~slot_free;
            owner_d = owner_q & ~slot_free;
            if (frame_tick && (pcool_q != 5'd0)) begin
                pcool_d = pcool_q - 5'd1;
            end else begin
                pcool_d = pcool_q;
            end
            if (frame_tick && (ecool_q != 5'd0)) begin
                ecool_d = ecool_q - 5'd1;
            end else begin
                ecool_d = ecool_q;
            end
            // A grant's cooldown load overrides the tick decrement above.
            if (slot_avail_s && player_req_s) begin
                busy_d[free_idx_s]  = 1'b1;
                owner_d[free_idx_s] = 1'b1;
                pcool_d   = COOL_LOAD;
                gvalid_d  = 1'b1;
                gslot_d   = free_idx_s;
                gplayer_d = 1'b1;
                genemy_d  = 3'd0;
            end else if (slot_avail_s && enemy_req_s) begin
                busy_d[free_idx_s]  = 1'b1;
                owner_d[free_idx_s] = 1'b0;
                ecool_d   = COOL_LOAD;
                rr_d      = enemy_pick_s + 3'd1;
                gvalid_d  = 1'b1;
                gslot_d   = free_idx_s;
                gplayer_d = 1'b0;
                genemy_d  = enemy_pick_s;
            end else begin
                gvalid_d  = 1'b0;
            end
            ready_d = (pcool_d == 5'd0) &&
                      (popcount(busy_d & owner_d) < CW'(PLAYER_MAX));
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q    <= '0;
            owner_q   <= '0;
            pcool_q   <= 5'd0;
            ecool_q   <= 5'd0;
            rr_q      <= 3'd0;
            gvalid_q  <= 1'b0;
            gslot_q   <= '0;
            gplayer_q <= 1'b0;
            genemy_q  <= 3'd0;
            ready_q   <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            pcool_q   <= pcool_d;
            ecool_q   <= ecool_d;
            rr_q      <= rr_d;
            gvalid_q  <= gvalid_d;
            gslot_q   <= gslot_d;
            gplayer_q <= gplayer_d;
            genemy_q  <= genemy_d;
            ready_q   <= ready_d;
        end
    end

    assign slot_busy    = busy_q;
    assign slot_owner   = owner_q;
    assign grant_valid  = gvalid_q;
    assign grant_slot   = gslot_q;
    assign grant_player = gplayer_q;
    assign grant_enemy  = genemy_q;
    assign player_ready = ready_q;

endmodule
